// File: rtl/mod_counter.sv
// mod_counter: parameterised modulo-N up-counter with a terminal-count pulse.
// Counts 0..N-1 and wraps, advancing on each rising clk edge where en is high.
// Out-of-range values (N..2^W-1) return to 0 on the next enabled edge.
module mod_counter #(
  parameter int N = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  output logic [$clog2(N)-1:0] Q,
  output logic                 tc
);

  localparam int W = $clog2(N);
  localparam logic [W-1:0] last_count = W'(N - 1);

  // A modulus below 2 has no meaningful count range, so refuse to elaborate
  generate
    if (N < 2) begin : g_bad_modulus
      $error("mod_counter: N must be >= 2");
    end
  endgenerate

  // Increment or wrap; >= catches unreachable values so the counter always recovers
  function automatic logic [W-1:0] count_next(input logic [W-1:0] cur);
    if (cur >= last_count) begin
      return '0;
    end else begin
      return cur + W'(1);
    end
  endfunction

  logic [W-1:0] q_next;

  // Next count: advance when enabled, otherwise hold the current value
  always_comb begin
    q_next = Q;
    if (en) begin
      q_next = count_next(Q);
    end
  end

  // Count register, cleared immediately whenever reset_n is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q <= '0;
    end else begin
      Q <= q_next;
    end
  end

  // Terminal count marks the cycle whose edge will wrap the counter
  always_comb begin
    tc = en && (Q == last_count);
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed self-checking bench for mod_counter.
// Covers reset, count/wrap, enable hold, async reset mid-count,
// N=16 and N=2 moduli, and a two-digit cascade chained through tc.
module tb_mod_counter;

  logic       clk;
  logic       reset_n;
  logic       en10;
  logic       en16;
  logic       en2;
  logic       enCasc;

  logic [3:0] q10;
  logic       tc10;
  logic [3:0] q16;
  logic       tc16;
  logic       q2;
  logic       tc2;
  logic [3:0] qLow;
  logic       tcLow;
  logic [3:0] qHigh;
  logic       tcHigh;

  int compareCount;
  int mismatchCount;

  mod_counter #(.N(10)) u_cnt10 (
    .clk(clk), .reset_n(reset_n), .en(en10), .Q(q10), .tc(tc10)
  );

  mod_counter #(.N(16)) u_cnt16 (
    .clk(clk), .reset_n(reset_n), .en(en16), .Q(q16), .tc(tc16)
  );

  mod_counter #(.N(2)) u_cnt2 (
    .clk(clk), .reset_n(reset_n), .en(en2), .Q(q2), .tc(tc2)
  );

  mod_counter #(.N(10)) u_cascLow (
    .clk(clk), .reset_n(reset_n), .en(enCasc), .Q(qLow), .tc(tcLow)
  );

  mod_counter #(.N(10)) u_cascHigh (
    .clk(clk), .reset_n(reset_n), .en(tcLow), .Q(qHigh), .tc(tcHigh)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, required finish before 50000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int required);
    compareCount++;
    if (observed !== required) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", tag, observed, required, $time);
    end
  endtask

  task automatic applyStimulus(input logic e10, input logic e16, input logic e2, input logic eC);
    en10   = e10;
    en16   = e16;
    en2    = e2;
    enCasc = eC;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expQ;
    compareCount  = 0;
    mismatchCount = 0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    #2;
    reset_n = 1'b1;
    #1;
    checkOutput("reset_q10", int'(q10), 0);
    checkOutput("reset_tc10", int'(tc10), 0);
    checkOutput("reset_q16", int'(q16), 0);
    checkOutput("reset_q2", int'(q2), 0);

    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick();
      expQ = (i + 1) % 10;
      checkOutput("count10_q", int'(q10), expQ);
      checkOutput("count10_tc", int'(tc10), (expQ == 9) ? 1 : 0);
    end

    tick();
    tick();
    checkOutput("pre_hold_q", int'(q10), 5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_q", int'(q10), 5);
      checkOutput("hold_tc", int'(tc10), 0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("resume_q", int'(q10), 6);
    tick();
    checkOutput("pre_async_q", int'(q10), 7);

    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_q", int'(q10), 0);
    checkOutput("async_reset_tc", int'(tc10), 0);
    reset_n = 1'b1;
    tick();
    checkOutput("after_reset_q", int'(q10), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("n16_start_q", int'(q16), 0);
    for (int i = 0; i < 17; i++) begin
      tick();
      expQ = (i + 1) % 16;
      checkOutput("n16_q", int'(q16), expQ);
      checkOutput("n16_tc", int'(tc16), (expQ == 15) ? 1 : 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("n16_idle_tc", int'(tc16), 0);

    checkOutput("n2_start_q", int'(q2), 0);
    checkOutput("n2_start_tc", int'(tc2), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expQ = (i + 1) % 2;
      checkOutput("n2_q", int'(q2), expQ);
      checkOutput("n2_tc", int'(tc2), expQ);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    for (int k = 1; k <= 100; k++) begin
      tick();
      checkOutput("casc_low_q", int'(qLow), k % 10);
      checkOutput("casc_low_tc", int'(tcLow), ((k % 10) == 9) ? 1 : 0);
      checkOutput("casc_high_q", int'(qHigh), (k / 10) % 10);
    end
    checkOutput("casc_final_low", int'(qLow), 0);
    checkOutput("casc_final_high", int'(qHigh), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("casc_idle_low", int'(qLow), 0);
    checkOutput("casc_idle_high", int'(qHigh), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parameterised modulo-N up-counter: counts 0, 1, …, N-1, then wraps to 0, advancing one step per enabled clock edge.
- Generic building block for clock dividers, tick generators, digit counters and sequencing.
- Single clock domain, asynchronous active-low reset, synchronous count enable.
- Optional terminal-count pulse for cascading.

Parameters:
- N, default 10, modulus (number of distinct states); legal range N >= 2. Elaboration error if N < 2.
- Derived localparam W = $clog2(N), the width of Q (N=10 -> 4 bits; N=2 -> 1 bit; N=16 -> 4 bits).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  synchronous count enable, active high.
- Q  output  W  current count value, registered.
- tc  output  1  terminal count: combinational, high when en=1 and Q==N-1. Optional to connect.

Behaviour:
- Reset:
  - reset_n=0 forces Q=0 immediately, independent of clk.
  - Q is held at 0 while reset_n=0.
  - tc=0 during reset, because Q=0 != N-1 for N >= 2.
- Deassertion: the first count can occur on the first rising clk edge after reset_n=1 with en=1. No synchroniser inside the block; the integrator guarantees reset release timing.
- On each rising clk edge with reset_n=1:
  - en=1 and Q==N-1 -> Q <= 0 (wrap).
  - en=1 and Q<N-1 -> Q <= Q+1.
  - en=0 -> Q holds.
- Latency: Q updates on the same edge that samples en=1; one-cycle register latency.
- Values N..2^W-1 are unreachable in normal operation. If one is reached (e.g. upset), the next enabled edge forces Q <= 0. Compare with >= N-1 so recovery is guaranteed.
- N a power of two: same rule, so wrap happens at 2^W-1 -> 0 with no overflow dependency.
- Reset asserted mid-count (any Q, any en): Q -> 0 asynchronously. Counting resumes from 0 after release.
- en toggling: each rising edge is evaluated independently, with no memory of prior en.
- tc is asserted for exactly the cycle in which the wrap edge will occur. Cascading a second counter's en from tc yields one increment per N enabled cycles.
- en=X or Z is a bench error. The design need not define behaviour for it.

Decomposition:
- No shared package required; W is local to the module.
- Single module, no sub-modules. The count-next logic (increment or wrap) may be a function inside the module.
- A cascaded two-digit wrapper (two mod_counter instances chained via tc) is a separate block, out of scope here.

Test Plan:
- Reset: reset_n=0 for 2 ns at t=0, then 1 -> Q=0 before the first clk edge; tc=0.
- Count and wrap (N=10, T=10 ns, en=1 from 4 ns) over 13 rising edges -> Q sequence 1,2,…,9,0,1,2,3; tc high exactly while Q=9.
- Enable hold: N=10, en=0 for 3 edges at Q=5 -> Q stays 5; en=1 on the next edge -> Q=6.
- Async reset mid-count: at Q=7, pulse reset_n low between edges -> Q=0 immediately, no clk edge needed; next enabled edge -> Q=1.
- Power-of-two and minimum modulus:
  - N=16 -> Q runs 0..15, then 0.
  - N=2 -> Q toggles 0,1,0,1; W=1.
  - tc correct in both cases.
- Cascade: two instances, N=10, second en = first tc -> after 100 enabled edges both Q=0; second Q increments once per 10 edges.
